ga_run_ctrl: RTL and testbench



---
 rtl/ga_run_ctrl.sv | 147 ++++++++++++++
 tb/tb_ga_run_ctrl.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ga_run_ctrl.sv
// GA run controller: launches a GA run on an enable edge, supervises it with a
// timeout, then streams the captured results as a checksummed UART byte frame.
module ga_run_ctrl #(
  parameter int         DATA_W      = 28,
  parameter int         NUM_CH      = 3,
  parameter int         TIMEOUT_CYC = 1000000,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5
) (
  input  logic                     CLK_i,
  input  logic                     RST_i,
  input  logic                     EN_i,
  input  logic                     MODE_i,
  output logic                     GA_START_o,
  input  logic                     GA_FINISHED_i,
  input  logic [NUM_CH*DATA_W-1:0] GA_RESULT_i,
  output logic                     TX_DV_o,
  output logic [7:0]               TX_BYTE_o,
  input  logic                     TX_DONE_i,
  output logic                     BUSY_o,
  output logic                     TIMEOUT_o,
  output logic [7:0]               RUN_CNT_o
);
  localparam int BPC  = (DATA_W + 7) / 8;
  localparam int CHW  = BPC * 8;
  localparam int NDB  = NUM_CH * BPC;
  localparam int FLEN = 2 + NDB + 1;
  localparam int IDXW = $clog2(FLEN);
  localparam int TCW  = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, SEND, WAIT_DONE} state_t;
  state_t state_q, state_d;

  logic                          en_q, fin_q;
  logic [TCW-1:0]                tcnt_q;
  logic [IDXW-1:0]               idx_q;
  logic [NUM_CH-1:0][CHW-1:0]    cap_q, cap_d;
  logic [NDB-1:0][7:0]           data_b;
  logic [7:0]                    chk, cur_byte;
  logic                          en_rise, fin_rise, tmo_hit, last_byte;
  logic                          launch, capture, timeout_evt, advance;

  // Channels are zero-extended to whole bytes at capture, so the packed capture
  // register is already the little-endian payload of the frame.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign cap_d[c] = CHW'(GA_RESULT_i[c*DATA_W +: DATA_W]);
  end
  assign data_b = cap_q;

  always_comb begin
    chk = RUN_CNT_o;
    for (int i = 0; i < NDB; i++) chk = chk ^ data_b[i];
  end

  always_comb begin
    cur_byte = chk;
    if (idx_q == '0) cur_byte = SYNC_BYTE;
    else if (idx_q == IDXW'(1)) cur_byte = RUN_CNT_o;
    for (int i = 0; i < NDB; i++)
      if (idx_q == IDXW'(i + 2)) cur_byte = data_b[i];
  end

  assign en_rise   = EN_i & ~en_q;
  assign fin_rise  = GA_FINISHED_i & ~fin_q;
  assign tmo_hit   = (tcnt_q == TCW'(TIMEOUT_CYC - 1));
  assign last_byte = (idx_q == IDXW'(FLEN - 1));

  always_comb begin
    state_d     = state_q;
    launch      = 1'b0;
    capture     = 1'b0;
    timeout_evt = 1'b0;
    advance     = 1'b0;
    case (state_q)
      IDLE:
        if (en_rise) begin
          state_d = LAUNCH;
          launch  = 1'b1;
        end
      LAUNCH:
        // a finish edge on the timeout cycle still counts as a completed run
        if (fin_rise) begin
          state_d = SEND;
          capture = 1'b1;
        end else if (tmo_hit) begin
          state_d     = IDLE;
          timeout_evt = 1'b1;
        end
      SEND:
        state_d = WAIT_DONE;
      WAIT_DONE:
        if (TX_DONE_i) begin
          if (!last_byte) begin
            state_d = SEND;
            advance = 1'b1;
          end else if (MODE_i && EN_i) begin
            state_d = LAUNCH;
            launch  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      default:
        state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      state_q    <= IDLE;
      en_q       <= 1'b0;
      fin_q      <= 1'b0;
      tcnt_q     <= '0;
      idx_q      <= '0;
      cap_q      <= '0;
      GA_START_o <= 1'b0;
      BUSY_o     <= 1'b0;
      TX_DV_o    <= 1'b0;
      TX_BYTE_o  <= 8'h00;
      TIMEOUT_o  <= 1'b0;
      RUN_CNT_o  <= 8'h00;
    end else begin
      state_q    <= state_d;
      en_q       <= EN_i;
      fin_q      <= GA_FINISHED_i;
      GA_START_o <= (state_d == LAUNCH);
      BUSY_o     <= (state_d != IDLE);
      // DV trails the SEND state by one cycle so the byte comes from the
      // already-updated capture register and run counter.
      TX_DV_o    <= (state_q == SEND);
      if (state_q == SEND) TX_BYTE_o <= cur_byte;

      if (launch || state_q == IDLE) tcnt_q <= '0;
      else if (state_q == LAUNCH)    tcnt_q <= tcnt_q + 1'b1;

      if (launch)           TIMEOUT_o <= 1'b0;
      else if (timeout_evt) TIMEOUT_o <= 1'b1;

      if (capture) begin
        cap_q     <= cap_d;
        RUN_CNT_o <= RUN_CNT_o + 1'b1;
        idx_q     <= '0;
      end else if (advance) begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ga_run_ctrl.sv
// Bench for ga_run_ctrl: two parameterisations, randomised UART DONE latency,
// frames checked against an arithmetic model of the frame format.
module tb_ga_run_ctrl;
  localparam int TMO = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, en = 1'b0, mode = 1'b0, fin = 1'b0, spur0 = 1'b0;
  logic [83:0] res0 = '0;
  logic [11:0] res1 = '0;
  logic        rdone0 = 1'b0, rdone1 = 1'b0;
  logic        done0, done1;
  logic        st0, dv0, busy0, tmo0, st1, dv1, busy1, tmo1;
  logic [7:0]  byte0, run0, byte1, run1;
  logic [7:0]  exp_run0 = 8'h00;
  logic [7:0]  q0[$], q1[$];
  int          nd0 = 0;
  int          checks = 0, errors = 0;

  assign done0 = rdone0 | spur0;
  assign done1 = rdone1;

  ga_run_ctrl #(.DATA_W(28), .NUM_CH(3), .TIMEOUT_CYC(TMO), .SYNC_BYTE(8'hA5)) u0 (
    .CLK_i(clk), .RST_i(rst), .EN_i(en), .MODE_i(mode), .GA_START_o(st0),
    .GA_FINISHED_i(fin), .GA_RESULT_i(res0), .TX_DV_o(dv0), .TX_BYTE_o(byte0),
    .TX_DONE_i(done0), .BUSY_o(busy0), .TIMEOUT_o(tmo0), .RUN_CNT_o(run0));

  ga_run_ctrl #(.DATA_W(12), .NUM_CH(1), .TIMEOUT_CYC(TMO), .SYNC_BYTE(8'hA5)) u1 (
    .CLK_i(clk), .RST_i(rst), .EN_i(en), .MODE_i(mode), .GA_START_o(st1),
    .GA_FINISHED_i(fin), .GA_RESULT_i(res1), .TX_DV_o(dv1), .TX_BYTE_o(byte1),
    .TX_DONE_i(done1), .BUSY_o(busy1), .TIMEOUT_o(tmo1), .RUN_CNT_o(run1));

  // byte capture and DONE counting
  always @(negedge clk) begin
    if (dv0) q0.push_back(byte0);
    if (dv1) q1.push_back(byte1);
  end
  always @(posedge clk) if (done0) nd0 <= nd0 + 1;

  // UART TX stand-ins: DONE 1..3 cycles after each DV
  initial forever begin
    @(negedge clk);
    if (dv0) begin
      repeat ($urandom_range(1, 3)) @(negedge clk);
      rdone0 = 1'b1; @(negedge clk); rdone0 = 1'b0;
    end
  end
  initial forever begin
    @(negedge clk);
    if (dv1) begin
      repeat ($urandom_range(1, 3)) @(negedge clk);
      rdone1 = 1'b1; @(negedge clk); rdone1 = 1'b0;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] data_byte(logic [255:0] res, int dw, int pos);
    int bpc = (dw + 7) / 8;
    logic [255:0] ch;
    ch = (res >> ((pos / bpc) * dw)) & ((256'd1 << dw) - 256'd1);
    return 8'(ch >> (8 * (pos % bpc)));
  endfunction

  function automatic logic [7:0] exp_byte(logic [255:0] res, int dw, int nch,
                                          logic [7:0] run, int pos);
    int flen = 3 + nch * ((dw + 7) / 8);
    logic [7:0] x;
    if (pos == 0) return 8'hA5;
    if (pos == 1) return run;
    if (pos == flen - 1) begin
      x = run;
      for (int p = 0; p < flen - 3; p++) x ^= data_byte(res, dw, p);
      return x;
    end
    return data_byte(res, dw, pos - 2);
  endfunction

  // number of wrong bytes in the frame starting at base (length error -> >=1000)
  function automatic int frame_diff(bit which, int base, logic [255:0] res, int dw,
                                    int nch, logic [7:0] run);
    int flen = 3 + nch * ((dw + 7) / 8);
    int n = which ? q1.size() : q0.size();
    int bad = 0;
    logic [7:0] got;
    if (n - base != flen) return 1000 + n - base;
    for (int i = 0; i < flen; i++) begin
      got = which ? q1[base+i] : q0[base+i];
      if (got !== exp_byte(res, dw, nch, run, i)) bad++;
    end
    return bad;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // rising EN edge sampled at the next posedge
  task automatic launch();
    @(negedge clk); en = 1'b0;
    @(negedge clk); en = 1'b1;
  endtask

  task automatic pulse_fin();
    @(negedge clk); fin = 1'b1;
    @(negedge clk); fin = 1'b0;
  endtask

  task automatic wait_idle(input bit which, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!(which ? busy1 : busy0)) begin ok = 1'b1; break; end
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    tick(2);
    rst = 1'b0;
    exp_run0 = 8'h00;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; en = 1'b0; mode = 1'b0; fin = 1'b0;
    tick(3);
    checks++;
    if ({st0, dv0, busy0, tmo0, byte0, run0} !== 12'h000) begin
      errors++;
      $display("FAIL reset_u0: start/dv/busy/tmo/byte/run = %b%b%b%b %h %h, want all 0",
               st0, dv0, busy0, tmo0, byte0, run0);
    end
    checks++;
    if ({st1, dv1, busy1, tmo1, byte1, run1} !== 12'h000) begin
      errors++;
      $display("FAIL reset_u1: start/dv/busy/tmo/byte/run = %b%b%b%b %h %h, want all 0",
               st1, dv1, busy1, tmo1, byte1, run1);
    end
    rst = 1'b0;
    exp_run0 = 8'h00;
  endtask

  task automatic test_single_shot();
    int base, nb, d;
    bit ok;
    mode = 1'b0;
    res0 = {28'h007C000, 28'h0038000, 28'h0010000};
    base = q0.size(); nb = nd0;
    launch();
    @(negedge clk);
    checks++;
    if (st0 !== 1'b1 || busy0 !== 1'b1) begin
      errors++; $display("FAIL ss_launch: start=%b busy=%b, want 1 1", st0, busy0);
    end
    tick(19);
    fin = 1'b1;
    @(negedge clk);
    checks++;
    if (st0 !== 1'b0 || busy0 !== 1'b1) begin
      errors++; $display("FAIL ss_start_drop: start=%b busy=%b, want 0 1", st0, busy0);
    end
    exp_run0++;
    wait_idle(1'b0, 400, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ss_idle: busy still 1 after 400 cycles, want 0"); end
    checks++;
    if (nd0 - nb != 15) begin
      errors++; $display("FAIL ss_done_cnt: busy fell after %0d DONEs, want 15", nd0 - nb);
    end
    d = frame_diff(1'b0, base, 256'(res0), 28, 3, exp_run0);
    checks++;
    if (d != 0) begin errors++; $display("FAIL ss_frame: %0d bad bytes, want 0", d); end
    checks++;
    if (q0.size() > base + 14 && q0[base+14] !== 8'h44) begin
      errors++; $display("FAIL ss_checksum: got %h, want 44", q0[base+14]);
    end
    checks++;
    if (run0 !== 8'h01 || tmo0 !== 1'b0) begin
      errors++; $display("FAIL ss_status: run=%h tmo=%b, want 01 0", run0, tmo0);
    end
    fin = 1'b0; en = 1'b0;
  endtask

  task automatic test_random_runs();
    int base, d;
    bit ok;
    mode = 1'b0;
    for (int it = 0; it < 6; it++) begin
      res0 = 84'({$urandom, $urandom, $urandom});
      res1 = 12'($urandom);
      base = q0.size();
      launch();
      tick($urandom_range(1, 50));
      pulse_fin();
      exp_run0++;
      wait_idle(1'b0, 400, ok);
      d = frame_diff(1'b0, base, 256'(res0), 28, 3, exp_run0);
      checks++;
      if (!ok || d != 0 || run0 !== exp_run0) begin
        errors++;
        $display("FAIL rand_frame[%0d]: idle=%b bad=%0d run=%h, want idle=1 bad=0 run=%h",
                 it, ok, d, run0, exp_run0);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_timeout();
    int base, d;
    bit ok;
    mode = 1'b0; fin = 1'b0;
    base = q0.size();
    launch();
    for (int j = 0; j <= TMO; j++) begin
      @(negedge clk);
      if (j == TMO - 1) begin
        checks++;
        if (tmo0 !== 1'b0 || busy0 !== 1'b1) begin
          errors++; $display("FAIL tmo_early: tmo=%b busy=%b at %0d, want 0 1", tmo0, busy0, j);
        end
      end
    end
    checks++;
    if (tmo0 !== 1'b1 || busy0 !== 1'b0 || st0 !== 1'b0) begin
      errors++;
      $display("FAIL tmo_hit: tmo=%b busy=%b start=%b, want 1 0 0", tmo0, busy0, st0);
    end
    checks++;
    if (q0.size() != base || run0 !== exp_run0) begin
      errors++;
      $display("FAIL tmo_noframe: dv=%0d run=%h, want dv=0 run=%h", q0.size() - base, run0, exp_run0);
    end
    tick(3);
    checks++;
    if (tmo0 !== 1'b1) begin errors++; $display("FAIL tmo_sticky: tmo=%b, want 1", tmo0); end
    launch();
    @(negedge clk);
    checks++;
    if (tmo0 !== 1'b0 || busy0 !== 1'b1) begin
      errors++; $display("FAIL tmo_clear: tmo=%b busy=%b, want 0 1", tmo0, busy0);
    end
    base = q0.size();
    tick(5);
    pulse_fin();
    exp_run0++;
    wait_idle(1'b0, 400, ok);
    d = frame_diff(1'b0, base, 256'(res0), 28, 3, exp_run0);
    checks++;
    if (!ok || d != 0) begin
      errors++; $display("FAIL tmo_recover: idle=%b bad=%0d, want 1 0", ok, d);
    end
    en = 1'b0;
  endtask

  task automatic test_continuous();
    int base, d;
    bit got;
    logic [7:0] lit_chk [3];
    lit_chk = '{8'h44, 8'h47, 8'h46};
    do_reset();
    mode = 1'b1;
    res0 = {28'h007C000, 28'h0038000, 28'h0010000};
    launch();
    @(negedge clk);
    checks++;
    if (st0 !== 1'b1) begin errors++; $display("FAIL cont_launch: start=%b, want 1", st0); end
    for (int r = 1; r <= 3; r++) begin
      base = q0.size();
      tick($urandom_range(2, 10));
      if (r == 3) en = 1'b0;
      pulse_fin();
      exp_run0++;
      got = 1'b0;
      for (int i = 0; i < 300; i++) begin
        @(negedge clk); #1;
        if (q0.size() - base >= 15) begin got = 1'b1; break; end
      end
      if (got) begin
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
          @(negedge clk); #1;
          if (done0) begin got = 1'b1; break; end
        end
      end
      checks++;
      if (!got) begin
        errors++; $display("FAIL cont_frame_end[%0d]: last DONE not seen, want seen", r);
      end
      @(negedge clk);
      checks++;
      if (st0 !== (r < 3) || busy0 !== (r < 3)) begin
        errors++;
        $display("FAIL cont_relaunch[%0d]: start=%b busy=%b, want %b %b", r, st0, busy0, r < 3, r < 3);
      end
      d = frame_diff(1'b0, base, 256'(res0), 28, 3, exp_run0);
      checks++;
      if (d != 0 || q0[base+1] !== 8'(r) || q0[base+14] !== lit_chk[r-1]) begin
        errors++;
        $display("FAIL cont_frame[%0d]: bad=%0d run=%h chk=%h, want 0 %h %h",
                 r, d, q0[base+1], q0[base+14], 8'(r), lit_chk[r-1]);
      end
    end
    mode = 1'b0;
  endtask

  task automatic test_stuck_fin();
    int base, d;
    bit ok;
    mode = 1'b0; fin = 1'b1;
    tick(2);
    base = q0.size();
    launch();
    for (int j = 0; j <= TMO; j++) @(negedge clk);
    checks++;
    if (tmo0 !== 1'b1 || busy0 !== 1'b0 || q0.size() != base) begin
      errors++;
      $display("FAIL stuck_fin: tmo=%b busy=%b dv=%0d, want 1 0 0", tmo0, busy0, q0.size() - base);
    end
    fin = 1'b0;
    launch();
    for (int j = 0; j < TMO; j++) begin
      @(negedge clk);
      if (j == 5) spur0 = 1'b1;
      if (j == 6) spur0 = 1'b0;
      if (j == 8) begin
        checks++;
        if (q0.size() != base || st0 !== 1'b1) begin
          errors++;
          $display("FAIL spurious_done: dv=%0d start=%b, want 0 1", q0.size() - base, st0);
        end
      end
    end
    fin = 1'b1;
    @(negedge clk);
    checks++;
    if (tmo0 !== 1'b0 || busy0 !== 1'b1 || st0 !== 1'b0) begin
      errors++;
      $display("FAIL fin_on_timeout: tmo=%b busy=%b start=%b, want 0 1 0", tmo0, busy0, st0);
    end
    fin = 1'b0;
    exp_run0++;
    wait_idle(1'b0, 400, ok);
    d = frame_diff(1'b0, base, 256'(res0), 28, 3, exp_run0);
    checks++;
    if (!ok || d != 0 || tmo0 !== 1'b0) begin
      errors++; $display("FAIL fin_on_timeout_frame: idle=%b bad=%0d tmo=%b, want 1 0 0", ok, d, tmo0);
    end
    en = 1'b0;
  endtask

  task automatic test_reset_mid();
    int base, nb, sz, d;
    bit got, ok;
    mode = 1'b0;
    res0 = 84'({$urandom, $urandom, $urandom});
    base = q0.size(); nb = nd0;
    launch();
    tick(4);
    pulse_fin();
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (nd0 - nb >= 5) begin got = 1'b1; break; end
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (!got || {st0, dv0, busy0, tmo0, byte0, run0} !== 12'h000) begin
      errors++;
      $display("FAIL reset_mid: reached=%b start/dv/busy/tmo/byte/run = %b%b%b%b %h %h, want all 0",
               got, st0, dv0, busy0, tmo0, byte0, run0);
    end
    rst = 1'b0; en = 1'b0;
    exp_run0 = 8'h00;
    sz = q0.size();
    checks++;
    if (sz - base != 5) begin
      errors++; $display("FAIL reset_mid_bytes: %0d bytes before reset, want 5", sz - base);
    end
    tick(20);
    checks++;
    if (q0.size() != sz) begin
      errors++; $display("FAIL reset_mid_quiet: %0d DVs after reset, want 0", q0.size() - sz);
    end
    base = q0.size();
    launch();
    tick(6);
    pulse_fin();
    exp_run0++;
    wait_idle(1'b0, 400, ok);
    d = frame_diff(1'b0, base, 256'(res0), 28, 3, exp_run0);
    checks++;
    if (!ok || d != 0 || q0[base+1] !== 8'h01) begin
      errors++;
      $display("FAIL reset_mid_fresh: idle=%b bad=%0d run_byte=%h, want 1 0 01", ok, d, q0[base+1]);
    end
    en = 1'b0;
  endtask

  task automatic test_param();
    int b0, b1, d0, d1, bad;
    bit ok0, ok1;
    logic [7:0] lit [5];
    lit = '{8'hA5, 8'h01, 8'hBC, 8'h0A, 8'hB7};
    do_reset();
    mode = 1'b0;
    res1 = 12'hABC;
    res0 = 84'({$urandom, $urandom, $urandom});
    b0 = q0.size(); b1 = q1.size();
    launch();
    tick($urandom_range(1, 30));
    pulse_fin();
    exp_run0++;
    wait_idle(1'b1, 400, ok1);
    wait_idle(1'b0, 400, ok0);
    bad = 0;
    if (q1.size() - b1 != 5) bad = 100;
    else for (int i = 0; i < 5; i++) if (q1[b1+i] !== lit[i]) bad++;
    checks++;
    if (!ok1 || bad != 0) begin
      errors++; $display("FAIL param_frame: idle=%b bad=%0d, want 1 0", ok1, bad);
    end
    d1 = frame_diff(1'b1, b1, 256'(res1), 12, 1, 8'h01);
    checks++;
    if (d1 != 0) begin errors++; $display("FAIL param_model: bad=%0d, want 0", d1); end
    d0 = frame_diff(1'b0, b0, 256'(res0), 28, 3, exp_run0);
    checks++;
    if (!ok0 || d0 != 0) begin
      errors++; $display("FAIL param_wide: idle=%b bad=%0d, want 1 0", ok0, d0);
    end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_shot();
    test_random_runs();
    test_timeout();
    test_continuous();
    test_stuck_fin();
    test_reset_mid();
    test_param();
    tick(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at 1 ms, want finished");
    $fatal(1, "watchdog expired");
  end
endmodule
